shape_pixel_renderer: RTL and testbench

Pipelined, parametrised tetromino pixel renderer for the VGA path. Given the current raster position, it reports whether the pixel lies in the interior, the border, or the drop-shadow ("ghost") of an N-cell falling piece. Piece coordinates are double-buffered so a piece never tears mid-frame, and a frame-counted blink mode flashes the piece. It sits between the game-logic piece register and the colour mapper.

---
 rtl/shape_pixel_renderer.sv | 159 +++++++++++++++
 tb/tb_shape_pixel_renderer.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/shape_pixel_renderer.sv
// Tetromino pixel renderer: classifies a raster pixel as piece interior,
// piece border or ghost, with double-buffered coordinates and blink.
module shape_pixel_renderer #(
   parameter int CELLS        = 4,
   parameter int COORD_W      = 5,
   parameter int CELL_PX      = 24,
   parameter int BORDER_PX    = 2,
   parameter int X_OFFSET     = 200,
   parameter int Y_OFFSET     = 0,
   parameter int BLINK_FRAMES = 8
) (
   input  logic                     Clk,
   input  logic                     Reset,
   input  logic [9:0]               DrawX,
   input  logic [9:0]               DrawY,
   input  logic                     pix_valid,
   input  logic                     frame_start,
   input  logic                     load,
   input  logic [CELLS*COORD_W-1:0] x_in,
   input  logic [CELLS*COORD_W-1:0] y_in,
   input  logic                     ghost_en,
   input  logic [COORD_W-1:0]       ghost_dy,
   input  logic                     blink_en,
   output logic                     is_shape,
   output logic                     is_boundary,
   output logic                     is_ghost,
   output logic                     out_valid
);

   localparam logic [11:0] XO = 12'(X_OFFSET);
   localparam logic [11:0] YO = 12'(Y_OFFSET);
   localparam logic [11:0] CP = 12'(CELL_PX);
   localparam logic [11:0] BP = 12'(BORDER_PX);
   localparam int          CNT_W = $clog2(BLINK_FRAMES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_FRAMES - 1);

   logic [CELLS*COORD_W-1:0] act_x, act_y, shd_x, shd_y;
   logic                     pending, shown;
   logic [CNT_W-1:0]         cnt;
   logic                     phase;

   logic [11:0]      dx, dy, rx, ry;
   logic             x_ok, y_ok;
   logic [CELLS-1:0] hit_c, int_c, gh_c;

   logic [CELLS-1:0] hit1, int1, gh1;
   logic             v1, shown1, ph1;
   logic             show;

   function automatic logic span_hit(input logic [11:0] r,
                                     input logic [11:0] c);
      logic [11:0] lo;
      lo = c * CP;
      return (r >= lo) && (r < lo + CP);
   endfunction

   function automatic logic span_in(input logic [11:0] r,
                                    input logic [11:0] c);
      logic [11:0] lo;
      lo = c * CP;
      return (r >= lo + BP) && (r < lo + CP - BP);
   endfunction

   // Simultaneous load+frame_start bypasses the shadow buffer.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         act_x   <= '0;
         act_y   <= '0;
         shd_x   <= '0;
         shd_y   <= '0;
         pending <= 1'b0;
         shown   <= 1'b0;
      end else if (load && frame_start) begin
         act_x   <= x_in;
         act_y   <= y_in;
         pending <= 1'b0;
         shown   <= 1'b1;
      end else if (load) begin
         shd_x   <= x_in;
         shd_y   <= y_in;
         pending <= 1'b1;
      end else if (frame_start && pending) begin
         act_x   <= shd_x;
         act_y   <= shd_y;
         pending <= 1'b0;
         shown   <= 1'b1;
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (!blink_en) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (frame_start) begin
         if (cnt == CNT_MAX) begin
            cnt   <= '0;
            phase <= ~phase;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign dx   = {2'b00, DrawX};
   assign dy   = {2'b00, DrawY};
   assign x_ok = dx >= XO;
   assign y_ok = dy >= YO;
   assign rx   = dx - XO;
   assign ry   = dy - YO;

   for (genvar i = 0; i < CELLS; i++) begin : g_cell
      logic [11:0] cx, cy, gy;
      assign cx = 12'(act_x[i*COORD_W +: COORD_W]);
      assign cy = 12'(act_y[i*COORD_W +: COORD_W]);
      assign gy = cy + 12'(ghost_dy);
      assign hit_c[i] = x_ok & y_ok & span_hit(rx, cx) & span_hit(ry, cy);
      assign int_c[i] = x_ok & y_ok & span_in(rx, cx) & span_in(ry, cy);
      assign gh_c[i]  = ghost_en & x_ok & y_ok
                      & span_hit(rx, cx) & span_hit(ry, gy);
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         hit1   <= '0;
         int1   <= '0;
         gh1    <= '0;
         v1     <= 1'b0;
         shown1 <= 1'b0;
         ph1    <= 1'b0;
      end else begin
         hit1   <= hit_c;
         int1   <= int_c;
         gh1    <= gh_c;
         v1     <= pix_valid;
         shown1 <= shown;
         ph1    <= phase;
      end
   end

   assign show = v1 & shown1 & ~ph1;

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         is_shape    <= 1'b0;
         is_boundary <= 1'b0;
         is_ghost    <= 1'b0;
         out_valid   <= 1'b0;
      end else begin
         is_shape    <= show & (|int1);
         is_boundary <= show & (|hit1) & ~(|int1);
         is_ghost    <= show & (|gh1) & ~(|hit1);
         out_valid   <= v1;
      end
   end

endmodule

// File: tb/tb_shape_pixel_renderer.sv
// Bench for shape_pixel_renderer: directed table, buffering, blink,
// reset sequences and a randomized stream against a geometric model.
module tb_shape_pixel_renderer;
   localparam int CELLS = 4;
   localparam int CW    = 5;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [9:0]        draw_x = '0, draw_y = '0;
   logic              pix_valid = 1'b0, frame_start = 1'b0, load = 1'b0;
   logic [CELLS*CW-1:0] x_in = '0, y_in = '0;
   logic              ghost_en = 1'b0, blink_en = 1'b0;
   logic [CW-1:0]     ghost_dy = '0;
   logic              is_shape, is_boundary, is_ghost, out_valid;

   int total = 0;
   int bad = 0;
   int xs[CELLS];
   int ys[CELLS];

   typedef struct {
      int         x;
      int         y;
      logic [2:0] want;
   } vec_t;

   vec_t tbl[9];

   shape_pixel_renderer dut (
      .Clk(clk), .Reset(rst_n), .DrawX(draw_x), .DrawY(draw_y),
      .pix_valid(pix_valid), .frame_start(frame_start), .load(load),
      .x_in(x_in), .y_in(y_in), .ghost_en(ghost_en), .ghost_dy(ghost_dy),
      .blink_en(blink_en), .is_shape(is_shape), .is_boundary(is_boundary),
      .is_ghost(is_ghost), .out_valid(out_valid)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [3:0] want);
      total++;
      if ({out_valid, is_shape, is_boundary, is_ghost} !== want) begin
         bad++;
         $display("FAIL %s got=%b want=%b (valid,shape,border,ghost)", nm,
                  {out_valid, is_shape, is_boundary, is_ghost}, want);
      end
   endtask

   task automatic put_piece(input int x, input int y);
      for (int i = 0; i < CELLS; i++) begin
         xs[i] = x;
         ys[i] = y;
         x_in[i*CW +: CW] = CW'(x);
         y_in[i*CW +: CW] = CW'(y);
      end
   endtask

   task automatic commit(input int x, input int y);
      put_piece(x, y);
      load = 1'b1;
      cyc();
      load = 1'b0;
      frame_start = 1'b1;
      cyc();
      frame_start = 1'b0;
   endtask

   task automatic pulse();
      frame_start = 1'b1;
      cyc();
      frame_start = 1'b0;
   endtask

   task automatic pix_chk(input string nm, input int x, input int y,
                          input logic [2:0] want);
      draw_x = 10'(x);
      draw_y = 10'(y);
      pix_valid = 1'b1;
      cyc();
      pix_valid = 1'b0;
      chk({nm, "_lat"}, 4'b0000);
      cyc();
      chk(nm, {1'b1, want});
   endtask

   function automatic logic [2:0] model(input int px, input int py,
                                        input bit gen, input int gdy);
      bit anyi = 0, anyh = 0, anyg = 0;
      for (int i = 0; i < CELLS; i++) begin
         int x0 = 200 + xs[i] * 24;
         int y0 = ys[i] * 24;
         int g0 = (ys[i] + gdy) * 24;
         bit hx = px >= x0 && px < x0 + 24;
         bit ix = px >= x0 + 2 && px < x0 + 22;
         if (hx && py >= y0 && py < y0 + 24) anyh = 1;
         if (ix && py >= y0 + 2 && py < y0 + 22) anyi = 1;
         if (hx && py >= g0 && py < g0 + 24) anyg = 1;
      end
      if (anyi) return 3'b100;
      if (anyh) return 3'b010;
      if (gen && anyg) return 3'b001;
      return 3'b000;
   endfunction

   initial begin
      logic [3:0] q[$];
      logic [3:0] w;

      tbl[0] = '{210, 10, 3'b100};
      tbl[1] = '{200, 10, 3'b010};
      tbl[2] = '{223, 23, 3'b010};
      tbl[3] = '{224, 10, 3'b000};
      tbl[4] = '{199, 10, 3'b000};
      tbl[5] = '{202, 2, 3'b100};
      tbl[6] = '{221, 21, 3'b100};
      tbl[7] = '{222, 10, 3'b010};
      tbl[8] = '{210, 24, 3'b000};

      cyc();
      cyc();
      chk("reset_state", 4'b0000);
      #2 rst_n = 1'b1;

      pix_chk("pre_commit", 210, 10, 3'b000);

      commit(0, 0);
      foreach (tbl[i])
         pix_chk($sformatf("tbl%0d", i), tbl[i].x, tbl[i].y, tbl[i].want);

      blink_en = 1'b1;
      for (int i = 0; i < 7; i++) pulse();
      pix_chk("blink_7", 210, 10, 3'b100);
      pulse();
      pix_chk("blink_8", 210, 10, 3'b000);
      for (int i = 0; i < 7; i++) pulse();
      pix_chk("blink_15", 210, 10, 3'b000);
      pulse();
      pix_chk("blink_16", 210, 10, 3'b100);
      for (int i = 0; i < 8; i++) pulse();
      pix_chk("blink_24", 210, 10, 3'b000);
      blink_en = 1'b0;
      cyc();
      pix_chk("blink_drop", 210, 10, 3'b100);

      put_piece(5, 5);
      load = 1'b1;
      cyc();
      load = 1'b0;
      pix_chk("dbuf_hold", 210, 10, 3'b100);
      draw_x = 10'd210;
      draw_y = 10'd10;
      pix_valid = 1'b1;
      frame_start = 1'b1;
      cyc();
      frame_start = 1'b0;
      draw_x = 10'd330;
      draw_y = 10'd130;
      cyc();
      pix_valid = 1'b0;
      chk("dbuf_old", 4'b1100);
      cyc();
      chk("dbuf_new", 4'b1100);
      pix_chk("dbuf_gone", 210, 10, 3'b000);

      put_piece(2, 2);
      load = 1'b1;
      cyc();
      put_piece(6, 6);
      cyc();
      load = 1'b0;
      pulse();
      pix_chk("overwrite_new", 354, 154, 3'b100);
      pix_chk("overwrite_old", 258, 58, 3'b000);

      commit(3, 2);
      ghost_en = 1'b1;
      ghost_dy = 5'd5;
      pix_chk("ghost_hit", 280, 180, 3'b001);
      ghost_en = 1'b0;
      pix_chk("ghost_off", 280, 180, 3'b000);
      ghost_en = 1'b1;
      ghost_dy = 5'd0;
      pix_chk("ghost_dy0", 280, 60, 3'b100);
      ghost_en = 1'b0;

      draw_x = 10'd280;
      draw_y = 10'd60;
      pix_valid = 1'b1;
      cyc();
      cyc();
      chk("rst_pre", 4'b1100);
      #2 rst_n = 1'b0;
      #1 chk("rst_async", 4'b0000);
      #2 rst_n = 1'b1;
      draw_x = 10'd210;
      draw_y = 10'd10;
      cyc();
      cyc();
      cyc();
      chk("rst_hold", 4'b1000);
      pix_valid = 1'b0;
      put_piece(1, 1);
      load = 1'b1;
      frame_start = 1'b1;
      cyc();
      load = 1'b0;
      frame_start = 1'b0;
      pix_chk("simul", 235, 35, 3'b100);

      for (int r = 0; r < 4; r++) begin
         bit gen;
         int gdy;
         for (int i = 0; i < CELLS; i++) begin
            xs[i] = $urandom_range(0, 17);
            ys[i] = $urandom_range(0, 19);
            x_in[i*CW +: CW] = CW'(xs[i]);
            y_in[i*CW +: CW] = CW'(ys[i]);
         end
         gen = 1'($urandom_range(0, 1));
         gdy = $urandom_range(0, 31);
         ghost_en = gen;
         ghost_dy = CW'(gdy);
         load = 1'b1;
         frame_start = 1'b1;
         cyc();
         load = 1'b0;
         frame_start = 1'b0;
         pix_valid = 1'b0;
         cyc();
         cyc();
         q.delete();
         for (int k = 0; k < 150; k++) begin
            int px, py, c;
            bit pv;
            c = $urandom_range(0, CELLS - 1);
            if ($urandom_range(0, 3) == 0) begin
               px = $urandom_range(0, 1023);
               py = $urandom_range(0, 1023);
            end else begin
               px = 200 + xs[c] * 24 + $urandom_range(0, 29) - 3;
               py = ($urandom_range(0, 1) == 1 ? ys[c] + gdy : ys[c]) * 24
                    + $urandom_range(0, 29) - 3;
            end
            if (py < 0) py = 0;
            if (py > 1023) py = 1023;
            pv = $urandom_range(0, 7) != 0;
            draw_x = 10'(px);
            draw_y = 10'(py);
            pix_valid = pv;
            q.push_back(pv ? {1'b1, model(px, py, gen, gdy)} : 4'b0000);
            cyc();
            if (q.size() == 2) begin
               w = q.pop_front();
               chk($sformatf("rand r%0d k%0d (%0d,%0d)", r, k, px, py), w);
            end
         end
         pix_valid = 1'b0;
         cyc();
         w = q.pop_front();
         chk("rand_drain", w);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
